// File: rtl/dmem_access_pkg.sv
// dmem_access_pkg: shared FSM states, funct3 constants and LDX select codes.
package dmem_access_pkg;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RD, S_RESP} state_e;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] LDX_LW  = 3'b000;
   localparam logic [2:0] LDX_LHU = 3'b001;
   localparam logic [2:0] LDX_LH  = 3'b010;
   localparam logic [2:0] LDX_LBU = 3'b011;
   localparam logic [2:0] LDX_LB  = 3'b100;
   function automatic logic f3_legal(input logic st, input logic [2:0] f3);
      return st ? (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW)
                : (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
   endfunction
   function automatic logic [2:0] ldx_of(input logic [2:0] f3);
      return f3 == F3_LW ? LDX_LW : f3 == F3_LHU ? LDX_LHU : f3 == F3_LH ? LDX_LH :
             f3 == F3_LBU ? LDX_LBU : LDX_LB;
   endfunction
endpackage

// File: rtl/dmem_access_store_align.sv
// store_align: byte-lane enables, lane-replicated store data and alignment check.
module store_align
   import dmem_access_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_wdata,
   output logic        misaligned
);
   logic b8, h16, w32;
   always_comb begin
      b8 = funct3 == F3_SB || funct3 == F3_LBU;
      h16 = funct3 == F3_SH || funct3 == F3_LHU;
      w32 = funct3 == F3_SW;
      mem_we = b8 ? 4'b0001 << addr_lo : h16 ? 4'b0011 << addr_lo : w32 ? 4'b1111 : 4'b0000;
      mem_wdata = b8 ? {4{wdata[7:0]}} : h16 ? {2{wdata[15:0]}} : wdata;
      misaligned = (h16 && addr_lo[0]) || (w32 && addr_lo != 2'b00);
   end
endmodule

// File: rtl/dmem_access.sv
// dmem_access: multi-cycle load/store unit with req/ready handshake, rvalid return and timeout.
module dmem_access
   import dmem_access_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata_raw,
   output logic [2:0]  ldx_sel,
   output logic [1:0]  addr_lo,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);
   localparam int CW = $clog2(TIMEOUT + 1);
   state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic st_q, done_q, err_q, err_d, mem_req_q;
   logic [31:0] rdata_q, mem_addr_q, mem_wdata_q, sa_wdata;
   logic [3:0] mem_we_q, sa_we;
   logic [2:0] ldx_q;
   logic [1:0] addr_lo_q;
   logic misaligned, bad, accept, busy, tmo;
   store_align u_align (
      .funct3(funct3),
      .addr_lo(addr[1:0]),
      .wdata(wdata),
      .mem_we(sa_we),
      .mem_wdata(sa_wdata),
      .misaligned(misaligned)
   );
   // Timeout beats a late mem_ready for loads so REQ+WAIT_RD never exceeds TIMEOUT cycles.
   always_comb begin
      accept = state_q == S_IDLE && valid;
      busy = state_q == S_REQ || state_q == S_WAIT_RD;
      bad = !f3_legal(is_store, funct3) || misaligned;
      tmo = cnt_q == CW'(TIMEOUT - 1);
      cnt_d = accept ? '0 : busy ? cnt_q + 1'b1 : cnt_q;
      state_d = state_q;
      err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            state_d = valid ? (bad ? S_RESP : S_REQ) : S_IDLE;
            err_d = bad;
         end
         S_REQ: begin
            state_d = (mem_ready && st_q) || tmo ? S_RESP : mem_ready ? S_WAIT_RD : S_REQ;
            err_d = !(mem_ready && st_q);
         end
         S_WAIT_RD: begin
            state_d = mem_rvalid || tmo ? S_RESP : S_WAIT_RD;
            err_d = !mem_rvalid;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         st_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
         mem_req_q <= 1'b0;
         mem_addr_q <= '0;
         mem_we_q <= '0;
         mem_wdata_q <= '0;
         ldx_q <= '0;
         addr_lo_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         done_q <= state_d == S_RESP;
         err_q <= state_d == S_RESP && err_d;
         mem_req_q <= state_d == S_REQ;
         if (accept) begin
            st_q <= is_store;
            mem_addr_q <= {addr[31:2], 2'b00};
            mem_we_q <= is_store && !bad ? sa_we : 4'b0000;
            mem_wdata_q <= sa_wdata;
            ldx_q <= is_store || bad ? LDX_LW : ldx_of(funct3);
            addr_lo_q <= addr[1:0];
         end
         if (state_q == S_WAIT_RD && mem_rvalid) rdata_q <= mem_rdata;
      end
   end
   assign stall = accept || busy;
   assign done = done_q;
   assign err = err_q;
   assign rdata_raw = rdata_q;
   assign ldx_sel = ldx_q;
   assign addr_lo = addr_lo_q;
   assign mem_req = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign mem_we = mem_we_q;
   assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: randomized scoreboard bench for dmem_access against a lane/size reference model.
module tb_dmem_access;
   localparam int TMO = 8;
   logic clk = 1'b0, rst = 1'b1, valid = 1'b0, is_store = 1'b0;
   logic [2:0] funct3 = '0;
   logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
   logic mem_ready = 1'b0, mem_rvalid = 1'b0;
   logic stall, done, err, mem_req;
   logic [31:0] rdata_raw, mem_addr, mem_wdata;
   logic [2:0] ldx_sel;
   logic [1:0] addr_lo;
   logic [3:0] mem_we;
   typedef struct {
      bit err;
      bit chk_rd;
      logic [31:0] rd;
      bit chk_ldx;
      logic [2:0] ldx;
      logic [1:0] alo;
      int cyc;
   } exp_t;
   exp_t sb[$];
   exp_t me;
   int tests = 0, fails = 0, cyc = 0;
   bit in_resp = 0;
   dmem_access #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .valid(valid), .is_store(is_store), .funct3(funct3),
      .addr(addr), .wdata(wdata), .stall(stall), .done(done), .err(err),
      .rdata_raw(rdata_raw), .ldx_sel(ldx_sel), .addr_lo(addr_lo), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", n, act, want, cyc);
      end
   endtask
   // Reference: access size in bytes decides alignment, lanes and replication.
   function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output bit bad, output logic [3:0] we,
                                 output logic [31:0] wdat, output logic [2:0] ldx);
      int size, off;
      bit legal;
      legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size = 1 << f3[1:0];
      off = int'(a[1:0]);
      bad = !legal || (off % size) != 0;
      we = '0;
      wdat = '0;
      for (int i = 0; i < 4; i++) begin
         we[i] = st && i >= off && i < off + size;
         wdat[8*i +: 8] = wd[8*(i % size) +: 8];
      end
      case (f3)
         3'd2: ldx = 3'd0;
         3'd5: ldx = 3'd1;
         3'd1: ldx = 3'd2;
         3'd4: ldx = 3'd3;
         default: ldx = 3'd4;
      endcase
      if (st) ldx = 3'd0;
   endfunction
   task automatic check_zero(input string n);
      chk({n, "_done"}, 32'(done), 0);
      chk({n, "_err"}, 32'(err), 0);
      chk({n, "_mem_req"}, 32'(mem_req), 0);
      chk({n, "_stall"}, 32'(stall), 0);
      chk({n, "_mem_we"}, 32'(mem_we), 0);
      chk({n, "_mem_addr"}, mem_addr, 0);
      chk({n, "_mem_wdata"}, mem_wdata, 0);
      chk({n, "_rdata_raw"}, rdata_raw, 0);
      chk({n, "_ldx_sel"}, 32'(ldx_sel), 0);
      chk({n, "_addr_lo"}, 32'(addr_lo), 0);
   endtask
   task automatic idle(input int n);
      valid = 0;
      mem_ready = 0;
      mem_rvalid = 0;
      repeat (n) @(posedge clk);
      #1;
      in_resp = 0;
   endtask
   // hang: 0 normal, 1 mem_ready never comes, 2 mem_rvalid never comes
   task automatic op(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input int rdly, input int vdly, input int hang, input logic [31:0] rd);
      bit bad, to, seen, req_exp;
      logic [3:0] we;
      logic [31:0] wdat;
      logic [2:0] ldx;
      exp_t e;
      int kd, acc;
      model(st, f3, a, wd, bad, we, wdat, ldx);
      to = !bad && (hang == 1 || (hang == 2 && !st));
      valid = 1;
      is_store = st;
      funct3 = f3;
      addr = a;
      wdata = wd;
      if (in_resp) begin
         @(posedge clk);
         #1;
      end
      acc = cyc;
      kd = bad ? 1 : to ? 1 + TMO : st ? 2 + rdly : 3 + rdly + vdly;
      e.err = bad || to;
      e.chk_rd = !bad && !st && !to;
      e.rd = rd;
      e.chk_ldx = !bad;
      e.ldx = ldx;
      e.alo = a[1:0];
      e.cyc = acc + kd;
      sb.push_back(e);
      @(negedge clk);
      chk("stall_accept", 32'(stall), 1);
      seen = 0;
      for (int k = 1; k <= TMO + 4 && !seen; k++) begin
         @(posedge clk);
         #1;
         mem_ready = hang != 1 && k == 1 + rdly;
         if (!st && hang == 0 && k == 2 + rdly + vdly) begin
            mem_rvalid = 1;
            mem_rdata = rd;
         end else if (k <= 1 + rdly) begin
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
         end else begin
            mem_rvalid = 0;
            mem_rdata = $urandom;
         end
         @(negedge clk);
         req_exp = !bad && (hang == 1 ? k <= TMO : k <= 1 + rdly);
         if (k == 1 && !bad) begin
            chk("mem_addr", mem_addr, {a[31:2], 2'b00});
            chk("mem_we", 32'(mem_we), 32'(we));
            if (st) chk("mem_wdata", mem_wdata, wdat);
         end
         if (done) begin
            seen = 1;
            chk("stall_resp", 32'(stall), 0);
            chk("mem_req_resp", 32'(mem_req), 0);
         end else begin
            chk("stall_busy", 32'(stall), 1);
            chk("mem_req", 32'(mem_req), 32'(req_exp));
         end
      end
      if (!seen) begin
         tests++;
         fails++;
         $display("FAIL op_no_done: no done within %0d cycles of accept at cycle %0d", TMO + 4, acc);
      end
      mem_ready = 0;
      mem_rvalid = 0;
      in_resp = 1;
   endtask
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: done=1, expected no done at cycle %0d", cyc);
         end else begin
            me = sb.pop_front();
            chk("done_cycle", 32'(cyc), 32'(me.cyc));
            chk("err", 32'(err), 32'(me.err));
            if (me.chk_rd) chk("rdata_raw", rdata_raw, me.rd);
            if (me.chk_ldx) chk("ldx_sel", 32'(ldx_sel), 32'(me.ldx));
            chk("addr_lo", 32'(addr_lo), 32'(me.alo));
         end
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      bit st;
      logic [2:0] f3;
      logic [31:0] a;
      int hang;
      logic [2:0] lf [5];
      lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      rst = 0;
      idle(1);
      op(1, 3'b000, 32'h1003, 32'h0000_00AB, 0, 0, 0, 0);
      idle(1);
      op(0, 3'b001, 32'h2002, 32'h0, 3, 1, 0, 32'h8001_7FFF);
      idle(2);
      op(0, 3'b010, 32'h4001, $urandom, 0, 0, 0, 0);
      op(1, 3'b001, 32'h11, $urandom, 0, 0, 0, 0);
      op(0, 3'b011, 32'h20, $urandom, 0, 0, 0, 0);
      idle(1);
      op(0, 3'b010, 32'h0, 0, 0, 0, 1, 0);
      op(0, 3'b100, 32'h33, 0, 1, 0, 2, 0);
      op(1, 3'b010, 32'h100, $urandom, 1, 0, 0, 0);
      op(0, 3'b100, 32'h7, 0, 0, 0, 0, $urandom);
      for (int n = 0; n < 60; n++) begin
         st = 1'($urandom_range(0, 1));
         f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
            : st ? lf[$urandom_range(0, 2)] : lf[$urandom_range(0, 4)];
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         hang = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 2)) : 0;
         op(st, f3, a, $urandom, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), hang, $urandom);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
      op(0, 3'b010, 32'h200, 0, 0, 0, 0, 32'hCAFE_F00D);
      idle(1);
      valid = 1;
      is_store = 0;
      funct3 = 3'b010;
      addr = 32'h100;
      @(posedge clk);
      #1;
      mem_ready = 1;
      @(posedge clk);
      #1;
      mem_ready = 0;
      valid = 0;
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      mem_rvalid = 1;
      mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check_zero("rst_mid");
      @(posedge clk);
      #1;
      mem_rvalid = 0;
      repeat (3) @(negedge clk);
      chk("late_rvalid_rdata", rdata_raw, 0);
      @(posedge clk);
      #1;
      in_resp = 0;
      op(0, 3'b010, 32'h0, 0, 0, 0, 0, 32'h1234_5678);
      idle(3);
      chk("scoreboard_empty", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
